// File: rtl/vga_sram_frame_writer.sv
// Stores a valid/ready RGB444 pixel stream into SRAM as a linear framebuffer, one AXI-Lite write per pixel.
// Optional back-buffer writing with a swap on every completed frame: VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN.
module vga_sram_frame_writer #(
  parameter int unsigned AXI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_DATA_WIDTH = 16,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  logic                              axi_clk,
  input  logic                              axi_resetn,
  input  logic                              enable,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_sof,
  input  logic [3:0]                        s_red,
  input  logic [3:0]                        s_green,
  input  logic [3:0]                        s_blue,
  output logic [AXI_ADDR_WIDTH-1:0]         axi_awaddr,
  output logic                              axi_awvalid,
  input  logic                              axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]         axi_wdata,
  output logic [(AXI_DATA_WIDTH+7)/8-1:0]   axi_wstrb,
  output logic                              axi_wvalid,
  input  logic                              axi_wready,
  input  logic [1:0]                        axi_bresp,
  input  logic                              axi_bvalid,
  output logic                              axi_bready,
  output logic                              frame_done,
  output logic                              write_error
`ifdef VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
  ,
  output logic                              active_buffer
`endif
);

  localparam int unsigned AW        = AXI_ADDR_WIDTH;
  localparam int unsigned DW        = AXI_DATA_WIDTH;
  localparam int unsigned STRB_W    = (AXI_DATA_WIDTH + 7) / 8;
  localparam int unsigned FRAME_PIX = H_VISIBLE * V_VISIBLE;
  localparam int unsigned CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned LAST_PIX  = FRAME_PIX - 1;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e            state_q;
  logic              rdy_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic [AW-1:0]     awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic              frame_done_q;
  logic              write_error_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  start_idx;
  logic [AW-1:0]     wr_base;
  logic              last_pix;

`ifdef VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
  logic ab_q;
  // Write into whichever buffer the reader is not displaying.
  assign wr_base       = AW'(BASE_ADDR) + (ab_q ? AW'(0) : AW'(FRAME_PIX));
  assign active_buffer = ab_q;
`else
  assign wr_base = AW'(BASE_ADDR);
`endif

  // Start-of-frame restarts the position before the pixel's address is formed.
  assign start_idx = s_sof ? '0 : cnt_q;
  assign last_pix  = (cnt_q == CNT_W'(LAST_PIX));
  assign cnt_d     = last_pix ? '0 : cnt_q + CNT_W'(1);

  // rdy_q is low in reset and outside IDLE, so s_ready tracks enable only while idle.
  assign s_ready     = rdy_q & enable;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = {STRB_W{1'b1}};
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign frame_done  = frame_done_q;
  assign write_error = write_error_q;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q       <= IDLE;
      rdy_q         <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      awaddr_q      <= AW'(BASE_ADDR);
      wdata_q       <= '0;
      frame_done_q  <= 1'b0;
      write_error_q <= 1'b0;
      cnt_q         <= '0;
`ifdef VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      ab_q          <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (s_valid && s_ready) begin
            awaddr_q  <= wr_base + AW'(start_idx);
            wdata_q   <= DW'({s_red, s_green, s_blue});
            cnt_q     <= start_idx;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            rdy_q     <= 1'b0;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          // Address and data channels complete independently.
          if (axi_awready) awvalid_q <= 1'b0;
          if (axi_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (axi_bvalid) begin
            bready_q      <= 1'b0;
            write_error_q <= write_error_q | (axi_bresp != 2'b00);
            cnt_q         <= cnt_d;
            if (last_pix) begin
              frame_done_q <= 1'b1;
`ifdef VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN
              ab_q         <= ~ab_q;
`endif
            end
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_sram_frame_writer.md
Name: vga_sram_frame_writer

Overview:
- AXI-Lite write initiator that stores an incoming valid/ready pixel stream into SRAM as a linear framebuffer.
- It is the write-side counterpart of the SRAM pixel streamer, which reads the framebuffer out to VGA.
- Sits between a pixel source (capture/decoder/test source) and the axi_sram_controller write channels.
- Issues one 16-bit write per pixel and tracks the frame position.

Parameters:
- AXI_ADDR_WIDTH, 20, write address width.
- AXI_DATA_WIDTH, 16, write data width; must be >= 12.
- H_VISIBLE, 640, pixels per line.
- V_VISIBLE, 480, lines per frame.
- BASE_ADDR, 0, word address of pixel (0,0).

Ports:
- axi_clk  input  1  single clock.
- axi_resetn  input  1  asynchronous active-low reset.
- enable  input  1  permits accepting new pixels.
- s_valid  input  1  pixel valid.
- s_ready  output  1  pixel accepted when s_valid & s_ready.
- s_sof  input  1  qualifies the pixel as the first of a frame.
- s_red  input  4  red.
- s_green  input  4  green.
- s_blue  input  4  blue.
- axi_awaddr  output  AXI_ADDR_WIDTH  write address.
- axi_awvalid  output  1  address valid.
- axi_awready  input  1  address ready.
- axi_wdata  output  AXI_DATA_WIDTH  write data.
- axi_wstrb  output  (AXI_DATA_WIDTH+7)/8  byte strobes.
- axi_wvalid  output  1  data valid.
- axi_wready  input  1  data ready.
- axi_bresp  input  2  write response.
- axi_bvalid  input  1  response valid.
- axi_bready  output  1  response ready.
- frame_done  output  1  one-cycle pulse after the last pixel's response.
- write_error  output  1  sticky flag, set on any bresp != 2'b00.

Behaviour:
- Reset (async, axi_resetn=0) forces all of the following immediately, including mid-transaction:
  - outputs: s_ready=0, awvalid=0, wvalid=0, bready=0, awaddr=BASE_ADDR, wdata=0, frame_done=0, write_error=0;
  - pixel counter=0;
  - state=IDLE.
- axi_wstrb is constant all-ones.
- wdata = zero-extended {red, green, blue}; red occupies bits [11:8].
- Pixel counter width is clog2(H_VISIBLE*V_VISIBLE). awaddr = BASE_ADDR + counter, truncated to AXI_ADDR_WIDTH.
- FSM states:
  - IDLE: s_ready = enable.
    - On s_valid & s_ready: latch the pixel into wdata and awaddr.
    - If s_sof: zero the counter first, so awaddr = BASE_ADDR.
    - Assert awvalid and wvalid next cycle; go to WRITE.
  - WRITE: awvalid and wvalid are held independently.
    - Each drops the cycle after its own handshake; the two handshakes may complete in the same or different cycles.
    - Payload stays stable while its valid is high.
    - When both handshakes are done, assert bready and go to RESP.
  - RESP: bready=1.
    - On bvalid, capture bresp into write_error (sticky OR).
    - Advance the counter. At H_VISIBLE*V_VISIBLE-1 it wraps to 0 and frame_done pulses that same cycle.
    - Go to IDLE.
- s_ready is 0 outside IDLE, so the block has at most one write outstanding.
- Throughput: one pixel per 3 cycles minimum (accept, AW/W handshake, B).
- Latency: awvalid/wvalid rise one cycle after the s_valid & s_ready handshake.
- enable low: no new pixels are accepted. An in-flight write completes normally.
- An s_sof arriving mid-frame resynchronises. The partial frame is abandoned and no frame_done is generated for it.
- s_sof on a pixel that also follows a wrap: the counter is already 0, so there is no effect.
- Any bresp error is recorded in write_error, but the counter still advances; the pixel is not retried.

Optional Feature:
- Macro: VGA_SRAM_FRAME_WRITER_DOUBLE_BUFFER_EN.
- When defined:
  - Adds output port active_buffer (1 bit, reset 0).
  - Write base = BASE_ADDR + (active_buffer ? 0 : H_VISIBLE*V_VISIBLE), so writes target the back buffer.
  - active_buffer toggles in the same cycle as frame_done, letting the reader display the completed frame.
- When undefined: no port, single buffer at BASE_ADDR.

Test Plan:
- Reset, then pixel s_sof=1, r=4'hA, g=4'h5, b=4'h3, with a 1-cycle responder -> one write, awaddr=0, wdata=16'h0A53, wstrb=2'b11. s_ready is high again 3 cycles after acceptance.
- awready delayed 4 cycles while wready is immediate -> wvalid drops after 1 cycle; awvalid and awaddr are held stable until the handshake; bready rises only after both handshakes complete.
- H_VISIBLE=4, V_VISIBLE=2, 9 consecutive pixels -> awaddr sequence 0..7 then 0; frame_done pulses exactly once, on the 8th bvalid.
- Stream 3 pixels, then s_sof on the 4th -> 4th write goes to awaddr=0; no frame_done is produced.
- bresp=2'b10 on the 2nd write -> write_error=1 and remains 1; the 3rd write goes to awaddr=2.
- Deassert axi_resetn during WRITE with awvalid=1 -> awvalid=0 and s_ready=0 immediately; after release, the next write goes to awaddr=BASE_ADDR.
- With DOUBLE_BUFFER_EN defined, H=4, V=2 -> frame 1 writes to addresses 8..15, frame 2 writes to 0..7; active_buffer toggles with each frame_done.
